// File: rtl/snake_row_reorder.sv
// Restores raster order from a snake-ordered row stream using two ping-pong row banks.
// Rows are written at their true column position, then drained left to right.
module snake_row_reorder #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   cfg_width,
    input  logic [AW:0]   cfg_rows,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_eol,
    output logic          busy,
    output logic          done
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   width_q, width_d;
    logic [AW:0]   rows_q, rows_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [AW:0]   wr_row_q, wr_row_d;
    logic [AW:0]   rd_row_q, rd_row_d;
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;

    logic [DW-1:0] mem [2*Depth];

    logic          run;
    logic [AW:0]   width_m1;
    logic [AW:0]   rows_m1;
    logic          wr_last;
    logic          rd_last;
    logic [AW-1:0] wr_addr;
    logic          in_hs;
    logic          out_hs;

    assign run      = (state_q == StRun);
    assign width_m1 = width_q - 1'b1;
    assign rows_m1  = rows_q - 1'b1;
    assign wr_last  = ({1'b0, wr_cnt_q} == width_m1);
    assign rd_last  = ({1'b0, rd_cnt_q} == width_m1);
    // Odd rows arrive right-to-left, so mirror the column index.
    assign wr_addr  = wr_row_q[0] ? (width_m1[AW-1:0] - wr_cnt_q) : wr_cnt_q;

    assign in_ready  = run && !full_q[wr_bank_q] && (wr_row_q < rows_q);
    assign out_valid = run && full_q[rd_bank_q];
    assign out_eol   = out_valid && rd_last;
    assign out_data  = out_valid ? mem[{rd_bank_q, rd_cnt_q}] : '0;
    assign busy      = run;
    assign done      = (state_q == StFin);

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        rows_d    = rows_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_row_d  = wr_row_q;
        rd_row_d  = rd_row_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    width_d   = cfg_width;
                    rows_d    = cfg_rows;
                    wr_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    wr_row_d  = '0;
                    rd_row_d  = '0;
                    full_d    = '0;
                    wr_bank_d = 1'b0;
                    rd_bank_d = 1'b0;
                    state_d   = ((cfg_width == '0) || (cfg_rows == '0)) ? StFin : StRun;
                end
            end
            StRun: begin
                if (in_hs) begin
                    if (wr_last) begin
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = ~wr_bank_q;
                        wr_cnt_d          = '0;
                        wr_row_d          = wr_row_q + 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
                // Set and clear always hit different banks, so both updates stand.
                if (out_hs) begin
                    if (rd_last) begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        rd_cnt_d          = '0;
                        rd_row_d          = rd_row_q + 1'b1;
                        if (rd_row_q == rows_m1) begin
                            state_d = StFin;
                        end
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            width_q   <= '0;
            rows_q    <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_row_q  <= '0;
            rd_row_q  <= '0;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            rows_q    <= rows_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_row_q  <= wr_row_d;
            rd_row_q  <= rd_row_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Bank storage carries no reset; contents are only read once a row is full.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            mem[{wr_bank_q, wr_addr}] <= in_data;
        end
    end

endmodule

// File: tb/tb_snake_row_reorder.sv
// Scoreboard bench for snake_row_reorder: raster expectations are queued per row as the
// snake-order row is driven, and popped on every output handshake.
module tb_snake_row_reorder;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   cfg_width;
    logic [AW:0]   cfg_rows;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          out_eol;
    logic          busy;
    logic          done;

    int            vectors = 0;
    int            miscompares = 0;
    logic [7:0]    exp_q[$];
    int            in_count = 0;
    int            out_count = 0;
    int            cur_w = 1;
    int            mon_col = 0;
    bit            rnd_ready = 1'b0;
    logic          ready_force = 1'b0;
    logic          prev_stall = 1'b0;
    logic [7:0]    prev_data = '0;

    snake_row_reorder #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_width (cfg_width),
        .cfg_rows  (cfg_rows),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_eol   (out_eol),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Scoreboard and hold-while-stalled monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    $display("FAIL stall_hold: valid=%b data=%0d required valid=1 data=%0d",
                             out_valid, out_data, prev_data);
                    miscompares++;
                end
            end
            if (in_valid && in_ready) in_count++;
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    $display("FAIL out_data: got %0d with no output expected", out_data);
                    miscompares++;
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        $display("FAIL out_data: got %0d required %0d", out_data, e);
                        miscompares++;
                    end
                end
                vectors++;
                if (out_eol !== (mon_col == cur_w - 1)) begin
                    $display("FAIL out_eol: got %b required %b at col %0d",
                             out_eol, (mon_col == cur_w - 1), mon_col);
                    miscompares++;
                end
                mon_col = (mon_col == cur_w - 1) ? 0 : mon_col + 1;
                out_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    function automatic logic [7:0] pix(int r, int c, int w);
        int v;
        v = r * w + c + ((r * w) >> 8);
        return v[7:0];
    endfunction

    task automatic do_start(int w, int rows);
        cur_w     = w;
        mon_col   = 0;
        cfg_width = w[AW:0];
        cfg_rows  = rows[AW:0];
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Drives up to nmax beats of a frame in snake order; pushes each row's raster values.
    task automatic drive_frame(int w, int rows, int nmax, int vprob);
        int n = 0;
        for (int r = 0; r < rows; r++) begin
            if (n >= nmax) break;
            for (int c = 0; c < w; c++) exp_q.push_back(pix(r, c, w));
            for (int k = 0; k < w; k++) begin
                int  col;
                int  tmo;
                bit  acc;
                if (n >= nmax) break;
                col = (r % 2 == 1) ? (w - 1 - k) : k;
                tmo = 0;
                acc = 1'b0;
                while (!acc) begin
                    in_valid = ($urandom_range(1, 100) <= vprob);
                    in_data  = pix(r, col, w);
                    @(negedge clk);
                    acc = in_valid && in_ready;
                    @(posedge clk);
                    #1;
                    tmo++;
                    if (tmo > 4000) begin
                        $display("FAIL input_timeout: row %0d beat %0d not accepted, required accept",
                                 r, k);
                        miscompares++;
                        vectors++;
                        in_valid = 1'b0;
                        return;
                    end
                end
                n++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(int limit, string name);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (!seen) begin
            $display("FAIL %s_done: done=0 after %0d cycles required 1", name, limit);
            miscompares++;
        end
    endtask

    task automatic check_drained(int n, string name);
        vectors++;
        if (out_count != n || exp_q.size() != 0) begin
            $display("FAIL %s_count: got %0d outputs, %0d pending, required %0d outputs, 0 pending",
                     name, out_count, exp_q.size(), n);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_width = '0; cfg_rows = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid, out_data, out_eol, busy, done} !== '0) begin
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%0d eol=%b busy=%b done=%b required all 0",
                     in_ready, out_valid, out_data, out_eol, busy, done);
            miscompares++;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        ready_force = 1'b1;
        out_count = 0;
        do_start(4, 2);
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL basic_busy: got %b required 1", busy);
            miscompares++;
        end
        fork
            drive_frame(4, 2, 8, 100);
            begin
                bit hit = 1'b0;
                for (int i = 0; i < 100 && !hit; i++) begin
                    @(negedge clk);
                    hit = in_valid && in_ready && (in_data == 8'd3);
                end
                vectors++;
                if (!hit || out_valid !== 1'b0) begin
                    $display("FAIL basic_pre_latency: hit=%b out_valid=%b required hit=1 valid=0",
                             hit, out_valid);
                    miscompares++;
                end
                @(negedge clk);
                vectors++;
                if (out_valid !== 1'b1 || out_data !== 8'd0) begin
                    $display("FAIL basic_latency: valid=%b data=%0d required valid=1 data=0",
                             out_valid, out_data);
                    miscompares++;
                end
            end
        join
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk);
                hit = out_valid && out_ready && (out_data == 8'd7);
            end
            vectors++;
            if (!hit || done !== 1'b0) begin
                $display("FAIL basic_last: hit=%b done=%b required hit=1 done=0", hit, done);
                miscompares++;
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                $display("FAIL basic_done: done=%b busy=%b required done=1 busy=0", done, busy);
                miscompares++;
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                $display("FAIL basic_done_pulse: done=%b required 0", done);
                miscompares++;
            end
            @(posedge clk);
            #1;
        end
        check_drained(8, "basic");
    endtask

    task automatic test_backpressure();
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        out_count = 0;
        in_count = 0;
        do_start(4, 3);
        fork
            drive_frame(4, 3, 12, 100);
            begin
                for (int i = 0; i < 200 && in_count < 8; i++) @(negedge clk);
                repeat (3) @(negedge clk);
                vectors++;
                if (in_count != 8 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd0) begin
                    $display("FAIL bp_full: accepted=%0d rdy=%b vld=%b data=%0d required 8 0 1 0",
                             in_count, in_ready, out_valid, out_data);
                    miscompares++;
                end
                ready_force = 1'b1;
            end
        join
        wait_done(200, "bp");
        check_drained(12, "bp");
    endtask

    task automatic test_back_to_back();
        ready_force = 1'b1;
        out_count = 0;
        do_start(256, 4);
        fork
            drive_frame(256, 4, 1024, 100);
            begin
                int hs = 0;
                int cycles = 0;
                for (int i = 0; i < 1000 && out_valid !== 1'b1; i++) @(negedge clk);
                for (int i = 0; i < 3000 && hs < 1024; i++) begin
                    if (out_valid && out_ready) hs++;
                    cycles++;
                    if (hs < 1024) @(negedge clk);
                end
                vectors++;
                if (hs != 1024 || cycles != 1024) begin
                    $display("FAIL b2b_bubbles: %0d outputs in %0d cycles required 1024 in 1024",
                             hs, cycles);
                    miscompares++;
                end
            end
        join
        wait_done(100, "b2b");
        check_drained(1024, "b2b");
    endtask

    task automatic test_random();
        out_count = 0;
        rnd_ready = 1'b1;
        do_start(5, 6);
        drive_frame(5, 6, 30, 60);
        wait_done(1000, "rand");
        rnd_ready = 1'b0;
        ready_force = 1'b1;
        check_drained(30, "rand");
    endtask

    task automatic test_zero_width();
        in_count = 0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        do_start(0, 3);
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL zero_done: done=%b busy=%b rdy=%b vld=%b required 1 0 0 0",
                     done, busy, in_ready, out_valid);
            miscompares++;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (done !== 1'b0 || in_count != 0 || out_valid !== 1'b0) begin
            $display("FAIL zero_idle: done=%b accepted=%0d vld=%b required 0 0 0",
                     done, in_count, out_valid);
            miscompares++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready_force = 1'b1;
        out_count = 0;
        do_start(4, 3);
        drive_frame(4, 3, 6, 100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_data, out_eol, busy, done} !== '0) begin
            $display("FAIL midreset_outputs: rdy=%b vld=%b data=%0d eol=%b busy=%b done=%b required all 0",
                     in_ready, out_valid, out_data, out_eol, busy, done);
            miscompares++;
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_count = 0;
        do_start(3, 1);
        drive_frame(3, 1, 3, 100);
        wait_done(50, "midreset");
        check_drained(3, "midreset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_zero_width();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
